// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - fetch PC sequencer with 2-bit-counter branch history table
module fetch_pc_ctrl #(
  parameter int unsigned BHT_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [31:0] imem_addr,
  output logic        fetch_valid,
  input  logic [31:0] dec_next_pc,
  input  logic [31:0] dec_taddr,
  input  logic        dec_is_br,
  input  logic        dec_is_jmp,
  output logic        pred_taken_f,
  output logic [31:0] pred_next_f,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_actual_next,
  input  logic [31:0] ex_pred_next,
  output logic        redirect,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int unsigned BHT_N = 1 << BHT_BITS;

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         branch_cnt_q, branch_cnt_d;
  logic [31:0]         mispred_cnt_q, mispred_cnt_d;
  logic [1:0]          bht_q [BHT_N];

  logic [BHT_BITS-1:0] f_idx;
  logic [BHT_BITS-1:0] ex_idx;
  logic [1:0]          ex_ctr;
  logic [1:0]          ex_ctr_upd;
  logic                bht_we;
  logic                in_boot;

  assign in_boot = (state_q == ST_BOOT);
  assign f_idx   = pc_q[BHT_BITS+1:2];
  assign ex_idx  = ex_pc[BHT_BITS+1:2];
  assign bht_we  = ex_valid & ex_is_br;

  assign redirect    = ex_valid & (ex_actual_next != ex_pred_next);
  assign imem_addr   = pc_q;
  assign fetch_valid = ~in_boot & (~stall | redirect);
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  // Prediction reads the registered counter, so a same-cycle update is not seen.
  always_comb begin
    pred_taken_f = 1'b0;
    pred_next_f  = dec_next_pc;
    if (in_boot) begin
      pred_next_f = pc_q;
    end else if (dec_is_jmp) begin
      pred_taken_f = 1'b1;
      pred_next_f  = dec_taddr;
    end else if (dec_is_br) begin
      pred_taken_f = bht_q[f_idx][1];
      pred_next_f  = bht_q[f_idx][1] ? dec_taddr : dec_next_pc;
    end
  end

  always_comb begin
    ex_ctr     = bht_q[ex_idx];
    ex_ctr_upd = ex_ctr;
    if (ex_taken) begin
      if (ex_ctr != 2'b11) ex_ctr_upd = ex_ctr + 2'b01;
    end else begin
      if (ex_ctr != 2'b00) ex_ctr_upd = ex_ctr - 2'b01;
    end
  end

  always_comb begin
    state_d = ST_RUN;
    if (redirect) begin
      pc_d = ex_actual_next;
    end else if (in_boot || stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pred_next_f;
    end
    branch_cnt_d  = branch_cnt_q + {31'd0, bht_we};
    mispred_cnt_d = mispred_cnt_q + {31'd0, redirect};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else if (bht_we) begin
      bht_q[ex_idx] <= ex_ctr_upd;
    end
  end

endmodule
